// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes pushed on wr_en are held in a
//   circular FIFO and sent LSB-first on tx with one start bit (0) and one
//   stop bit (1). Successive frames run back-to-back with no idle gap.
//
// Parameters
//   CLK_FREQ            system clock in Hz
//   BAUD_RATE           line rate; BAUD_TICKS = CLK_FREQ/BAUD_RATE (>= 1)
//   FIFO_DEPTH_BITWIDTH FIFO holds 2^N bytes
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   wr_en     in   push wr_data this cycle (accepted only if full == 0)
//   wr_data   in   byte to transmit
//   full      out  FIFO holds 2^N bytes; writes are dropped
//   overflow  out  sticky: a write arrived while full; cleared only by rst
//   busy      out  FIFO non-empty or frame in progress
//   count     out  bytes queued (excluding the one in the shifter)
//   tx        out  serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ            = 20_250_000,
    parameter int BAUD_RATE           = 9600,
    parameter int FIFO_DEPTH_BITWIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         full,
    output logic                         overflow,
    output logic                         busy,
    output logic [FIFO_DEPTH_BITWIDTH:0] count,
    output logic                         tx
);

    localparam int N          = FIFO_DEPTH_BITWIDTH;
    localparam int DEPTH      = 1 << N;
    localparam int BAUD_TICKS = CLK_FREQ / BAUD_RATE;
    // One-bit counter even when BAUD_TICKS == 1; it then simply stays at 0
    // and every cycle is a bit end.
    localparam int BAUD_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_TICKS - 1);
    localparam logic [N:0]        DEPTH_CNT = (N+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Storage and registers
    // ---------------------------------------------------------------
    logic [7:0]        mem [DEPTH];

    state_t            state_reg,    state_next;
    logic [BAUD_W-1:0] baud_reg,     baud_next;
    logic [2:0]        bit_reg,      bit_next;
    logic [7:0]        shift_reg,    shift_next;
    logic              tx_reg,       tx_next;
    logic [N-1:0]      wr_ptr_reg,   wr_ptr_next;
    logic [N-1:0]      rd_ptr_reg,   rd_ptr_next;
    logic [N:0]        count_reg,    count_next;
    logic              full_reg,     full_next;
    logic              overflow_reg, overflow_next;
    logic              busy_reg,     busy_next;

    logic              push;
    logic              pop;
    logic              bit_end;
    logic              queued;

    // Fullness is judged on the registered (pre-edge) value, so a pop in
    // the same cycle never rescues a write that arrives while full.
    assign push    = wr_en && !full_reg;
    assign bit_end = (baud_reg == BAUD_LAST);
    assign queued  = (count_reg != '0);

    // ---------------------------------------------------------------
    // FIFO write port (no reset: plain RAM contents)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
            busy_reg     <= busy_next;
        end
    end

    // ---------------------------------------------------------------
    // Transmit FSM: next state, line value, shifter, baud timing
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                baud_next = '0;
                if (queued) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    tx_next    = shift_reg[0];
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // The bit being put on the line is the one that
                        // becomes shift_reg[0] after this shift.
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (queued) begin
                        // Chain directly into the next start bit.
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                baud_next  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FIFO bookkeeping and registered status outputs
    // ---------------------------------------------------------------
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | (wr_en & full_reg);

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        // Status flags are computed from next-state values so that the
        // registered outputs agree with count/state in the same cycle.
        full_next = (count_next == DEPTH_CNT);
        busy_next = (count_next != '0) || (state_next != IDLE);
    end

    assign tx       = tx_reg;
    assign full     = full_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Two instances: inst0 at 4 clocks per bit, inst1 at 1 clock per bit.
//   A queue-based model predicts the line waveform and status outputs of
//   each instance every cycle; directed sequences are followed by a
//   randomized write phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       wr_en_s   [2];
    logic [7:0] wr_data_s [2];
    logic       full_s    [2];
    logic       overflow_s[2];
    logic       busy_s    [2];
    logic [3:0] count_s   [2];
    logic       tx_s      [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ           (20_250_000),
        .BAUD_RATE          (5_062_500),
        .FIFO_DEPTH_BITWIDTH(3)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s[0]),
        .wr_data (wr_data_s[0]),
        .full    (full_s[0]),
        .overflow(overflow_s[0]),
        .busy    (busy_s[0]),
        .count   (count_s[0]),
        .tx      (tx_s[0])
    );

    uart_tx_fifo #(
        .CLK_FREQ           (20_250_000),
        .BAUD_RATE          (20_250_000),
        .FIFO_DEPTH_BITWIDTH(3)
    ) dut1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s[1]),
        .wr_data (wr_data_s[1]),
        .full    (full_s[1]),
        .overflow(overflow_s[1]),
        .busy    (busy_s[1]),
        .count   (count_s[1]),
        .tx      (tx_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: a byte queue plus the list of line values still
    // to be driven for the frame in flight (one entry per clock).
    // ---------------------------------------------------------------
    byte unsigned mq   [2][$];
    bit           line [2][$];
    bit           m_ovf [2];
    bit           m_tx  [2];
    bit           m_busy[2];

    always @(posedge clk or posedge rst) begin
        int           pre;
        int           ticks;
        byte unsigned b;
        bit           v;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                line[i].delete();
                m_ovf[i]  = 1'b0;
                m_tx[i]   = 1'b1;
                m_busy[i] = 1'b0;
            end else begin
                ticks = (i == 0) ? 4 : 1;
                pre   = mq[i].size();
                if (line[i].size() == 0 && pre > 0) begin
                    b = mq[i].pop_front();
                    $display("inst%0d frame 0x%02h", i, b);
                    for (int j = 0; j < 10; j++) begin
                        if (j == 0)      v = 1'b0;
                        else if (j == 9) v = 1'b1;
                        else             v = b[j-1];
                        repeat (ticks) line[i].push_back(v);
                    end
                end
                if (wr_en_s[i]) begin
                    if (pre < DEPTH) begin
                        mq[i].push_back(wr_data_s[i]);
                        $display("inst%0d push 0x%02h queued=%0d", i, wr_data_s[i], mq[i].size());
                    end else begin
                        m_ovf[i] = 1'b1;
                        $display("inst%0d drop 0x%02h (queue full)", i, wr_data_s[i]);
                    end
                end
                m_busy[i] = (mq[i].size() != 0) || (line[i].size() != 0);
                m_tx[i]   = (line[i].size() != 0) ? line[i].pop_front() : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("tx%0d", i),       tx_s[i],       m_tx[i]);
                check($sformatf("busy%0d", i),     busy_s[i],     m_busy[i]);
                check($sformatf("count%0d", i),    count_s[i],    mq[i].size());
                check($sformatf("full%0d", i),     full_s[i],     mq[i].size() == DEPTH);
                check($sformatf("overflow%0d", i), overflow_s[i], m_ovf[i]);
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic cyc(input bit e0, input logic [7:0] d0, input bit e1, input logic [7:0] d1);
        @(negedge clk);
        wr_en_s[0]   = e0;
        wr_data_s[0] = d0;
        wr_en_s[1]   = e1;
        wr_data_s[1] = d1;
    endtask

    task automatic drain();
        int n = 0;
        cyc(0, 8'h00, 0, 8'h00);
        while ((m_busy[0] || m_busy[1]) && n < 5000) begin
            cyc(0, 8'h00, 0, 8'h00);
            n++;
        end
        check("drain_bound", n < 5000, 1);
        repeat (3) cyc(0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        rst          = 1'b1;
        wr_en_s[0]   = 1'b0;
        wr_en_s[1]   = 1'b0;
        wr_data_s[0] = 8'h00;
        wr_data_s[1] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle line after reset.
        repeat (100) cyc(0, 8'h00, 0, 8'h00);

        // Single frame.
        cyc(1, 8'hAA, 1, 8'hAA);
        drain();

        // Two back-to-back frames.
        cyc(1, 8'h55, 1, 8'h55);
        cyc(1, 8'hC3, 1, 8'hC3);
        drain();

        // Ten consecutive writes: fill to full, last one dropped.
        for (int k = 0; k < 10; k++) cyc(1, 8'(k), 1, 8'(k));
        cyc(0, 8'h00, 0, 8'h00);
        check("ovf_after_burst0", overflow_s[0], 1);
        check("full_after_burst0", full_s[0], 1);
        drain();
        check("ovf_sticky0", overflow_s[0], 1);

        // Reset in the middle of data bit 3 of 0xF0.
        cyc(1, 8'hF0, 0, 8'h00);
        repeat (18) cyc(0, 8'h00, 0, 8'h00);
        check("pre_rst_tx0", tx_s[0], 0);
        check("pre_rst_busy0", busy_s[0], 1);
        #2 rst = 1'b1;
        #1;
        check("rst_tx0", tx_s[0], 1);
        check("rst_count0", count_s[0], 0);
        check("rst_ovf0", overflow_s[0], 0);
        check("rst_busy0", busy_s[0], 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 8'h81, 1, 8'h81);
        drain();

        // Randomized writes.
        for (int c = 0; c < 1500; c++) begin
            cyc($urandom_range(0, 7) == 0, 8'($urandom),
                $urandom_range(0, 5) == 0, 8'($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
